// File: rtl/adder_arbiter_if.sv
// Handshake and datapath bundle between the two operand front-ends, the
// adder arbiter, the response consumer and the shared CLA/RCA datapath.
interface adder_arbiter_if #(
    parameter int WIDTH = 24
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_use_rca;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_use_rca;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_cout;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_use_rca;
    logic [WIDTH:0]   add_z;

    logic             busy;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_use_rca,
        input  req1_valid, req1_a, req1_b, req1_use_rca,
        input  rsp_ready, add_z,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_z, rsp_cout,
        output add_a, add_b, add_use_rca, busy
    );

    // Requesters, response consumer and adder datapath side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_use_rca,
        output req1_valid, req1_a, req1_b, req1_use_rca,
        output rsp_ready, add_z,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_z, rsp_cout,
        input  add_a, add_b, add_use_rca, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one multicycle WIDTH-bit adder between two
// requesters. One operation in flight: accept, hold operands for SETTLE
// cycles, capture sum/carry, return it tagged with the requester id.
module adder_arbiter #(
    parameter int WIDTH  = 24,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic             id_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic             add_use_rca_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_z_q;
    logic             rsp_cout_q;
    logic             busy_q;

    logic             grant_vld_d;
    logic             grant_id_d;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_d;
    logic             op_rca_d;

    // Round-robin grant, re-evaluated every IDLE cycle; contention goes to the requester not served last.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_id_d  = 1'b0;
        if (!rst && (state_q == ST_IDLE)) begin
            case ({bus.req1_valid, bus.req0_valid})
                2'b01: begin
                    grant_vld_d = 1'b1;
                    grant_id_d  = 1'b0;
                end
                2'b10: begin
                    grant_vld_d = 1'b1;
                    grant_id_d  = 1'b1;
                end
                2'b11: begin
                    grant_vld_d = 1'b1;
                    grant_id_d  = ~last_grant_q;
                end
                default: begin
                    grant_vld_d = 1'b0;
                    grant_id_d  = 1'b0;
                end
            endcase
        end else begin
            grant_vld_d = 1'b0;
            grant_id_d  = 1'b0;
        end
    end

    // Steer the granted requester's operands and adder select toward the operand registers.
    always_comb begin
        op_a_d   = bus.req0_a;
        op_b_d   = bus.req0_b;
        op_rca_d = bus.req0_use_rca;
        if (grant_id_d) begin
            op_a_d   = bus.req1_a;
            op_b_d   = bus.req1_b;
            op_rca_d = bus.req1_use_rca;
        end else begin
            op_a_d   = bus.req0_a;
            op_b_d   = bus.req0_b;
            op_rca_d = bus.req0_use_rca;
        end
    end

    // Sequencer: accept one request, hold operands for SETTLE cycles, capture the result, wait for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            add_a_q       <= {WIDTH{1'b0}};
            add_b_q       <= {WIDTH{1'b0}};
            add_use_rca_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_z_q       <= {WIDTH{1'b0}};
            rsp_cout_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d) begin
                        add_a_q       <= op_a_d;
                        add_b_q       <= op_b_d;
                        add_use_rca_q <= op_rca_d;
                        id_q          <= grant_id_d;
                        last_grant_q  <= grant_id_d;
                        cnt_q         <= CNT_LOAD;
                        busy_q        <= 1'b1;
                        state_q       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_ZERO) begin
                        rsp_z_q     <= bus.add_z[WIDTH-1:0];
                        rsp_cout_q  <= bus.add_z[WIDTH];
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    // Returning to IDLE here means the earliest next accept is the following edge.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready  = grant_vld_d && !grant_id_d;
    assign bus.req1_ready  = grant_vld_d && grant_id_d;
    assign bus.add_a       = add_a_q;
    assign bus.add_b       = add_b_q;
    assign bus.add_use_rca = add_use_rca_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_z       = rsp_z_q;
    assign bus.rsp_cout    = rsp_cout_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a SETTLE=2 instance driven through directed and
// random operations, plus a SETTLE=1 instance for latency and spacing.
module tb_adder_arbiter;
    localparam int W  = 24;
    localparam int ST = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic last_m;

    adder_arbiter_if #(.WIDTH(W)) bus2 ();
    adder_arbiter_if #(.WIDTH(W)) bus1 ();

    adder_arbiter #(.WIDTH(W), .SETTLE(ST)) dut (.clk(clk), .rst(rst), .bus(bus2));
    adder_arbiter #(.WIDTH(W), .SETTLE(1))  dut_s1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multicycle adder model: the sum is only correct once operands have been held ST cycles.
    logic [W-1:0] pa2;
    logic [W-1:0] pb2;
    logic         pr2;
    int           age2 = 0;
    logic         chg2;
    int           held2;
    logic [W:0]   sum2;

    always @(posedge clk) begin
        if (bus2.add_a !== pa2 || bus2.add_b !== pb2 || bus2.add_use_rca !== pr2) begin
            pa2  <= bus2.add_a;
            pb2  <= bus2.add_b;
            pr2  <= bus2.add_use_rca;
            age2 <= 1;
        end else if (age2 < 1000) begin
            age2 <= age2 + 1;
        end
    end

    always_comb begin
        chg2  = (bus2.add_a !== pa2) || (bus2.add_b !== pb2) || (bus2.add_use_rca !== pr2);
        held2 = chg2 ? 1 : age2 + 1;
        sum2  = {1'b0, bus2.add_a} + {1'b0, bus2.add_b};
        bus2.add_z = (held2 >= ST) ? sum2 : ~sum2;
    end

    assign bus1.add_z = {1'b0, bus1.add_a} + {1'b0, bus1.add_b};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus2.req0_valid = 1'b0; bus2.req0_a = '0; bus2.req0_b = '0; bus2.req0_use_rca = 1'b0;
        bus2.req1_valid = 1'b0; bus2.req1_a = '0; bus2.req1_b = '0; bus2.req1_use_rca = 1'b0;
        bus2.rsp_ready  = 1'b0;
        bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_use_rca = 1'b0;
        bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_use_rca = 1'b0;
        bus1.rsp_ready  = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        rst    = 1'b0;
        last_m = 1'b1;
    endtask

    // One complete operation on the SETTLE=2 instance, starting in an IDLE cycle.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input bit r0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input bit r1,
                          input int stall, input bit junk, input bit wd, input string tag);
        logic         w;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         er;
        logic [W:0]   es;
        bus2.req0_valid = v0; bus2.req0_a = a0; bus2.req0_b = b0; bus2.req0_use_rca = r0;
        bus2.req1_valid = v1; bus2.req1_a = a1; bus2.req1_b = b1; bus2.req1_use_rca = r1;
        bus2.rsp_ready  = 1'b0;
        w = (v0 && v1) ? ~last_m : (v0 ? 1'b0 : 1'b1);
        #1;
        n_cmp++;
        if ({bus2.busy, bus2.req1_ready, bus2.req0_ready} !== {1'b0, w, ~w}) begin
            n_bad++;
            $display("FAIL %s grant: busy,rdy1,rdy0=%b%b%b want 0%b%b", tag,
                     bus2.busy, bus2.req1_ready, bus2.req0_ready, w, ~w);
        end
        if (wd && v0 && v1) begin
            if (w) bus2.req1_valid = 1'b0;
            else   bus2.req0_valid = 1'b0;
            w = ~w;
            #1;
            n_cmp++;
            if ({bus2.req1_ready, bus2.req0_ready} !== {w, ~w}) begin
                n_bad++;
                $display("FAIL %s withdraw: rdy1,rdy0=%b%b want %b%b", tag,
                         bus2.req1_ready, bus2.req0_ready, w, ~w);
            end
        end
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        er = w ? r1 : r0;
        es = {1'b0, ea} + {1'b0, eb};
        tick();
        last_m = w;
        n_cmp++;
        if ({bus2.busy, bus2.rsp_valid, bus2.add_use_rca} !== {1'b1, 1'b0, er} ||
            bus2.add_a !== ea || bus2.add_b !== eb) begin
            n_bad++;
            $display("FAIL %s accept: busy=%b rsp_valid=%b a=%h b=%h rca=%b want 1 0 %h %h %b", tag,
                     bus2.busy, bus2.rsp_valid, bus2.add_a, bus2.add_b, bus2.add_use_rca, ea, eb, er);
        end
        if (junk) begin
            bus2.req0_valid = 1'($urandom_range(0, 1)); bus2.req0_a = W'($urandom);
            bus2.req1_valid = 1'($urandom_range(0, 1)); bus2.req1_b = W'($urandom);
            bus2.rsp_ready  = 1'($urandom_range(0, 1));
        end
        for (int i = 1; i < ST; i++) begin
            tick();
            n_cmp++;
            if ({bus2.busy, bus2.rsp_valid, bus2.req1_ready, bus2.req0_ready, bus2.add_use_rca} !== {4'b1000, er} ||
                bus2.add_a !== ea || bus2.add_b !== eb) begin
                n_bad++;
                $display("FAIL %s settle: busy,vld,rdy1,rdy0,rca=%b%b%b%b%b a=%h b=%h want 1000%b %h %h", tag,
                         bus2.busy, bus2.rsp_valid, bus2.req1_ready, bus2.req0_ready, bus2.add_use_rca,
                         bus2.add_a, bus2.add_b, er, ea, eb);
            end
        end
        tick();
        bus2.rsp_ready = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) tick();
            #1;
            n_cmp++;
            if ({bus2.rsp_valid, bus2.rsp_id, bus2.rsp_cout, bus2.busy, bus2.req1_ready, bus2.req0_ready} !==
                {1'b1, w, es[W], 3'b100} || bus2.rsp_z !== es[W-1:0] || bus2.add_a !== ea) begin
                n_bad++;
                $display("FAIL %s resp%0d: vld,id,cout,busy,rdy1,rdy0=%b%b%b%b%b%b z=%h want 1%b%b100 z=%h", tag, s,
                         bus2.rsp_valid, bus2.rsp_id, bus2.rsp_cout, bus2.busy, bus2.req1_ready, bus2.req0_ready,
                         bus2.rsp_z, w, es[W], es[W-1:0]);
            end
        end
        bus2.rsp_ready = 1'b1;
        if (junk) begin
            bus2.req0_valid = 1'b1;
            bus2.req1_valid = 1'b1;
        end
        #1;
        n_cmp++;
        if ({bus2.req1_ready, bus2.req0_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s rsp_hs_no_accept: rdy1,rdy0=%b%b want 00", tag, bus2.req1_ready, bus2.req0_ready);
        end
        tick();
        bus2.rsp_ready = 1'b0;
        n_cmp++;
        if ({bus2.rsp_valid, bus2.busy} !== 2'b00 || bus2.add_a !== ea || bus2.add_b !== eb) begin
            n_bad++;
            $display("FAIL %s release: vld,busy=%b%b a=%h b=%h want 00 %h %h", tag,
                     bus2.rsp_valid, bus2.busy, bus2.add_a, bus2.add_b, ea, eb);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        bus2.req0_valid = 1'b1;
        bus2.req1_valid = 1'b1;
        bus1.req0_valid = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus2.req0_ready, bus2.req1_ready, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_cout, bus2.add_use_rca, bus2.busy} !== 7'b0 ||
            bus2.rsp_z !== 24'h0 || bus2.add_a !== 24'h0 || bus2.add_b !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_s2: ctl=%b z=%h a=%h b=%h want all zero",
                     {bus2.req0_ready, bus2.req1_ready, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_cout, bus2.add_use_rca, bus2.busy},
                     bus2.rsp_z, bus2.add_a, bus2.add_b);
        end
        n_cmp++;
        if ({bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_cout, bus1.add_use_rca, bus1.busy} !== 7'b0 ||
            bus1.rsp_z !== 24'h0 || bus1.add_a !== 24'h0 || bus1.add_b !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_s1: ctl=%b z=%h a=%h b=%h want all zero",
                     {bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_cout, bus1.add_use_rca, bus1.busy},
                     bus1.rsp_z, bus1.add_a, bus1.add_b);
        end
        rst = 1'b0;
        clear_inputs();
        last_m = 1'b1;
        tick();
    endtask

    task automatic test_single_op;
        do_reset();
        run_op(1'b1, 1'b0, 24'hFFFFFF, 24'h000001, 1'b0, 24'h0, 24'h0, 1'b0, 0, 1'b0, 1'b0, "single");
    endtask

    task automatic test_contention;
        do_reset();
        for (int k = 0; k < 4; k++)
            run_op(1'b1, 1'b1, 24'h123456, 24'h111111, 1'b0, 24'h123456, 24'h222222, 1'b0, 0, 1'b0, 1'b0, "contention");
    endtask

    task automatic test_backpressure;
        run_op(1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5B, 1'b0, 24'h000010, 24'h000020, 1'b1, 5, 1'b0, 1'b0, "backpressure");
        run_op(1'b1, 1'b1, 24'h0F0F0F, 24'h010101, 1'b1, 24'h7FFFFF, 24'h000001, 1'b0, 0, 1'b0, 1'b0, "after_bp");
    endtask

    task automatic test_rca;
        run_op(1'b0, 1'b1, 24'h0, 24'h0, 1'b0, 24'h800000, 24'h800000, 1'b1, 0, 1'b0, 1'b0, "rca");
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus2.req0_valid = 1'b1; bus2.req0_a = 24'h333333; bus2.req0_b = 24'h444444;
        #1;
        n_cmp++;
        if (bus2.req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_accept: rdy0=%b want 1", bus2.req0_ready);
        end
        tick();
        bus2.req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus2.req0_ready, bus2.req1_ready, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_cout, bus2.add_use_rca, bus2.busy} !== 7'b0 ||
            bus2.rsp_z !== 24'h0 || bus2.add_a !== 24'h0 || bus2.add_b !== 24'h0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: ctl=%b z=%h a=%h b=%h want all zero",
                     {bus2.req0_ready, bus2.req1_ready, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_cout, bus2.add_use_rca, bus2.busy},
                     bus2.rsp_z, bus2.add_a, bus2.add_b);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({bus2.rsp_valid, bus2.busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL rst_mid_no_rsp: vld,busy=%b%b want 00", bus2.rsp_valid, bus2.busy);
            end
        end
        last_m = 1'b1;
        run_op(1'b1, 1'b1, 24'h000001, 24'h000002, 1'b0, 24'h000003, 24'h000004, 1'b0, 0, 1'b0, 1'b0, "rst_mid_next");
    endtask

    task automatic test_random;
        int p;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus2.req0_valid = 1'b0;
                bus2.req1_valid = 1'b0;
                bus2.rsp_ready  = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if ({bus2.busy, bus2.rsp_valid, bus2.req1_ready, bus2.req0_ready} !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL idle_gap: busy,vld,rdy1,rdy0=%b%b%b%b want 0000",
                             bus2.busy, bus2.rsp_valid, bus2.req1_ready, bus2.req0_ready);
                end
                tick();
            end
            p = $urandom_range(1, 3);
            run_op(p[0], p[1], W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b1, ($urandom_range(0, 2) == 0), "random");
        end
        clear_inputs();
    endtask

    task automatic test_settle1;
        logic [W:0] e;
        do_reset();
        bus1.req0_a = 24'hABCDEF; bus1.req0_b = 24'h543211;
        bus1.rsp_ready  = 1'b1;
        bus1.req0_valid = 1'b1;
        e = {1'b0, bus1.req0_a} + {1'b0, bus1.req0_b};
        #1;
        n_cmp++;
        if ({bus1.busy, bus1.req1_ready, bus1.req0_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL s1_grant: busy,rdy1,rdy0=%b%b%b want 001", bus1.busy, bus1.req1_ready, bus1.req0_ready);
        end
        tick();
        bus1.req0_valid = 1'b0;
        n_cmp++;
        if ({bus1.rsp_valid, bus1.busy} !== 2'b01 || bus1.add_a !== 24'hABCDEF) begin
            n_bad++;
            $display("FAIL s1_settle: vld,busy=%b%b a=%h want 01 abcdef", bus1.rsp_valid, bus1.busy, bus1.add_a);
        end
        tick();
        n_cmp++;
        if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_cout} !== {2'b10, e[W]} || bus1.rsp_z !== e[W-1:0]) begin
            n_bad++;
            $display("FAIL s1_resp: vld,id,cout=%b%b%b z=%h want 10%b z=%h",
                     bus1.rsp_valid, bus1.rsp_id, bus1.rsp_cout, bus1.rsp_z, e[W], e[W-1:0]);
        end
        tick();
        n_cmp++;
        if ({bus1.rsp_valid, bus1.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL s1_release: vld,busy=%b%b want 00", bus1.rsp_valid, bus1.busy);
        end
        bus1.req0_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_cmp++;
            if ({bus1.req0_ready, bus1.rsp_valid} !== {(c % 3) == 0, (c % 3) == 2} ||
                ((c % 3) == 2 && bus1.rsp_z !== e[W-1:0])) begin
                n_bad++;
                $display("FAIL s1_b2b cycle %0d: rdy0,vld=%b%b z=%h want %b%b z=%h", c,
                         bus1.req0_ready, bus1.rsp_valid, bus1.rsp_z, (c % 3) == 0, (c % 3) == 2, e[W-1:0]);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        last_m = 1'b1;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_rca();
        test_reset_mid();
        test_random();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequencer and arbiter that shares the single WIDTH-bit adder datapath (CLA/RCA pair) between two requesters. Each requester submits operands over a valid/ready handshake. The block grants one request at a time using round-robin, drives the adder operands and the CLA/RCA select, and waits a programmable number of settle cycles for the multicycle adder path. It then captures sum and carry-out and returns them on a shared response channel tagged with the requester ID. It sits between the operand front-ends (serial loader, coin/test logic) and the `cla`/`rca` instances in the top level.

## Interface

- `WIDTH`, 24, operand width in bits; the adder result is WIDTH+1 bits.
- `SETTLE`, 2, cycles the operands are held on the adder before its result is sampled; legal range 1..15.

- `clk`  in  1  system clock, the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  requester n has operands pending.
- `req0_ready` / `req1_ready`  out  1  request n accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_use_rca` / `req1_use_rca`  in  1  selects the adder: 1 = RCA result, 0 = CLA result.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that issued the response.
- `rsp_z`  out  WIDTH  sum.
- `rsp_cout`  out  1  carry-out (bit WIDTH of the adder result).
- `add_a`, `add_b`  out  WIDTH  operands to the adder datapath.
- `add_use_rca`  out  1  result-mux select toward the adder datapath.
- `add_z`  in  WIDTH+1  result from the selected adder.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- The state machine has three states: IDLE, SETTLE, RESP.
- **IDLE**
  - `busy`=0.
  - Grant selection:
    - Only one `reqN_valid` high: grant N.
    - Both high: grant the requester that is not `last_grant`.
  - `reqN_ready` is driven combinationally as (state==IDLE && granted==N). At most one ready is high per cycle.
  - On a handshake (valid && ready):
    - Register a, b, use_rca and the id into `add_a`/`add_b`/`add_use_rca` and the id register.
    - Set `last_grant`=N.
    - Load the settle counter with SETTLE-1.
    - Go to SETTLE.
- **SETTLE**
  - `add_*` are held stable.
  - The counter decrements each cycle.
  - When the counter is 0:
    - Capture `rsp_z`=`add_z[WIDTH-1:0]` and `rsp_cout`=`add_z[WIDTH]`.
    - Go to RESP.
  - `reqN_valid` is ignored in this state.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_id`, `rsp_z` and `rsp_cout` are stable.
  - When `rsp_ready`=1: `rsp_valid` drops on the next cycle and the state goes to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Arithmetic is unsigned modulo 2^WIDTH; wrap-around is reported only through `rsp_cout`. The block performs no arithmetic itself.
- `add_a`, `add_b` and `add_use_rca` keep their last values after the response until the next accept.
- A requester may deassert valid before it is granted. Arbitration is re-evaluated every IDLE cycle, and a deasserted requester is never granted.
- The counter width is clog2(SETTLE+1) bits. SETTLE=1 gives a single SETTLE cycle.

## Timing

- All outputs reset to 0: `req*_ready`, `rsp_valid`, `rsp_id`, `rsp_z`, `rsp_cout`, `add_a`, `add_b`, `add_use_rca`, `busy`.
- After reset the state is IDLE and `last_grant`=1, so requester 0 wins the first contention.
- Latency, with the accept at clock edge t:
  - `add_*` update at t.
  - `add_z` is sampled at edge t+SETTLE.
  - `rsp_valid` is first high in the cycle after edge t+SETTLE.
- Minimum spacing between accepts is SETTLE+2 cycles (zero rsp backpressure).
- Throughput is one operation in flight. A second requester waits in IDLE arbitration.
- Reset mid-operation (any state, any cycle):
  - State goes to IDLE and the in-flight operation is discarded.
  - No response is produced.
  - `last_grant` returns to 1.
- Simultaneous events:
  - Both requests arriving on the same cycle resolve by round-robin.
  - `rsp_ready` asserted while `rsp_valid`=0 has no effect.

## Test plan

- Single op: req0 a=0xFFFFFF, b=0x000001, use_rca=0, SETTLE=2, rsp_ready=1 → `req0_ready` pulses 1 cycle; `rsp_valid` high exactly 3 cycles after accept with z=0x000000, cout=1, id=0; `busy` high for 3 cycles plus the handshake.
- Contention: req0 and req1 held valid continuously, a=0x123456, b=0x111111 (req1: b=0x222222) → accept order 0,1,0,1; responses alternate id with z=0x234567 / 0x345678, cout=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after `rsp_valid` → rsp fields stable, both `req*_ready`=0; release → `rsp_valid` falls next cycle and the next accept occurs no earlier than the cycle after.
- RCA select: req1 a=0x800000, b=0x800000, use_rca=1 → `add_use_rca`=1 during SETTLE; response z=0x000000, cout=1, id=1.
- Reset mid-SETTLE: assert rst one cycle after accept → no `rsp_valid`; all outputs 0; the next simultaneous request grants req0.
- SETTLE=1 build: single req0 op → `rsp_valid` 2 cycles after accept; back-to-back ops spaced 3 cycles apart.
